// File: rtl/ahb_slave_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb_slave_ctrl_pkg
// Description : Shared AHB-Lite codes and controller state encoding for the
//               AHB slave memory front-end.
// Revision    : 1.0 - initial release
// ============================================================================
package ahb_slave_ctrl_pkg;

    // HTRANS transfer types
    localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] c_HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] c_HTRANS_SEQ    = 2'b11;

    // HSIZE transfer sizes
    localparam logic [2:0] c_HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] c_HSIZE_HALF  = 3'd1;
    localparam logic [2:0] c_HSIZE_WORD  = 3'd2;
    localparam logic [2:0] c_HSIZE_DWORD = 3'd3;

    // HRESP codes
    localparam logic c_HRESP_OKAY  = 1'b0;
    localparam logic c_HRESP_ERROR = 1'b1;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WDATA = 3'd1,
        ST_RDATA = 3'd2,
        ST_RWAIT = 3'd3,
        ST_RHAZ  = 3'd4,
        ST_ERR1  = 3'd5,
        ST_ERR2  = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ahb_slave_bsel_dec.sv
`default_nettype none
// ============================================================================
// Module      : ahb_slave_bsel_dec
// Description : Decodes HSIZE and the address lane bits into contiguous byte
//               enables, and flags oversize or misaligned transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_slave_bsel_dec #(
    parameter int DATA_BITS = 32
) (
    input  logic [2:0]                     i_hsize,
    input  logic [$clog2(DATA_BITS/8)-1:0] i_addr_lsb,
    output logic [DATA_BITS/8-1:0]         o_bsel,
    output logic                           o_size_err,
    output logic                           o_misaligned
);

    localparam int c_NB  = DATA_BITS / 8;
    localparam int c_LSB = $clog2(c_NB);

    int w_lane;
    int w_nbytes;

    // Lane window is [lane, lane + 2^size); oversize transfers enable nothing
    always_comb begin
        w_lane       = int'(i_addr_lsb);
        w_nbytes     = 1 << i_hsize;
        o_size_err   = (int'(i_hsize) > c_LSB);
        o_misaligned = ((w_lane & (w_nbytes - 1)) != 0);
        o_bsel       = '0;
        for (int i = 0; i < c_NB; i++) begin
            o_bsel[i] = !o_size_err && (i >= w_lane) && (i < (w_lane + w_nbytes));
        end
    end

endmodule
`default_nettype wire

// File: rtl/ahb_slave_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ahb_slave_ctrl
// Description : AHB-Lite slave front-end for a memory with one write port and
//               one read port. Decodes address/data phases, generates byte
//               lanes, resolves write-then-read same-word hazards, inserts
//               read wait states and produces two-cycle ERROR responses.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_slave_ctrl
    import ahb_slave_ctrl_pkg::*;
#(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 32,
    parameter int READ_WAIT = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   HSEL,
    input  logic [31:0]            HADDR,
    input  logic [1:0]             HTRANS,
    input  logic                   HWRITE,
    input  logic [2:0]             HSIZE,
    input  logic [DATA_BITS-1:0]   HWDATA,
    input  logic                   HREADY,
    output logic                   HREADYOUT,
    output logic                   HRESP,
    output logic [DATA_BITS-1:0]   HRDATA,
    output logic                   WR,
    output logic [ADDR_BITS-1:0]   ADDR_WR,
    output logic [DATA_BITS-1:0]   DIN,
    output logic [DATA_BITS/8-1:0] BSEL,
    output logic                   RD,
    output logic [ADDR_BITS-1:0]   ADDR_RD,
    input  logic [DATA_BITS-1:0]   DOUT
);

    localparam int         c_NB        = DATA_BITS / 8;
    localparam int         c_LSB       = $clog2(c_NB);
    localparam logic [1:0] c_WAIT_LOAD = (READ_WAIT > 0) ? 2'(READ_WAIT - 1) : 2'd0;
    localparam state_t     c_READ_NEXT = (READ_WAIT > 0) ? ST_RWAIT : ST_RDATA;

    state_t                r_state;
    logic [ADDR_BITS-1:0]  r_waddr;
    logic [ADDR_BITS-1:0]  r_raddr;
    logic [c_NB-1:0]       r_bsel;
    logic [1:0]            r_wcnt;
    logic [DATA_BITS-1:0]  r_hrdata;

    logic                  w_accept;
    logic                  w_decode_ok;
    logic                  w_range_err;
    logic                  w_size_err;
    logic                  w_misaligned;
    logic                  w_err;
    logic                  w_hazard;
    logic                  w_rd_now;
    logic [c_NB-1:0]       w_bsel;

    ahb_slave_bsel_dec #(
        .DATA_BITS (DATA_BITS)
    ) u_bsel_dec (
        .i_hsize      (HSIZE),
        .i_addr_lsb   (HADDR[c_LSB-1:0]),
        .o_bsel       (w_bsel),
        .o_size_err   (w_size_err),
        .o_misaligned (w_misaligned)
    );

    assign w_accept    = HSEL && HREADY &&
                         ((HTRANS == c_HTRANS_NONSEQ) || (HTRANS == c_HTRANS_SEQ));
    // States in which a new address phase can be taken
    assign w_decode_ok = (r_state == ST_IDLE)  || (r_state == ST_WDATA) ||
                         (r_state == ST_RDATA) || (r_state == ST_ERR2);
    assign w_range_err = ((HADDR >> ADDR_BITS) != '0);
    assign w_err       = w_range_err || w_size_err || w_misaligned;
    // A read of the word still being written this cycle must wait one cycle
    assign w_hazard    = (r_state == ST_WDATA) &&
                         (HADDR[ADDR_BITS-1:c_LSB] == r_waddr[ADDR_BITS-1:c_LSB]);
    assign w_rd_now    = w_accept && w_decode_ok && !HWRITE && !w_err && !w_hazard;

    // Transfer sequencing: address latching, wait counting and state advance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_waddr <= '0;
            r_raddr <= '0;
            r_bsel  <= '0;
            r_wcnt  <= 2'd0;
        end else begin
            case (r_state)
                ST_IDLE, ST_WDATA, ST_RDATA, ST_ERR2: begin
                    if (w_accept) begin
                        if (w_err) begin
                            r_state <= ST_ERR1;
                        end else if (HWRITE) begin
                            r_state <= ST_WDATA;
                            r_waddr <= HADDR[ADDR_BITS-1:0];
                            r_bsel  <= w_bsel;
                        end else if (w_hazard) begin
                            r_state <= ST_RHAZ;
                            r_raddr <= HADDR[ADDR_BITS-1:0];
                        end else begin
                            r_state <= c_READ_NEXT;
                            r_wcnt  <= c_WAIT_LOAD;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RHAZ: begin
                    r_state <= c_READ_NEXT;
                    r_wcnt  <= c_WAIT_LOAD;
                end
                ST_RWAIT: begin
                    if (r_wcnt == 2'd0) begin
                        r_state <= ST_RDATA;
                    end else begin
                        r_wcnt <= r_wcnt - 2'd1;
                    end
                end
                ST_ERR1: begin
                    r_state <= ST_ERR2;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Bus handshake and response decoded from the current state
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = c_HRESP_OKAY;
        case (r_state)
            ST_RWAIT, ST_RHAZ: begin
                HREADYOUT = 1'b0;
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = c_HRESP_ERROR;
            end
            ST_ERR2: begin
                HRESP     = c_HRESP_ERROR;
            end
            default: begin
            end
        endcase
    end

    // Memory write port is driven only in the write data phase
    assign WR      = (r_state == ST_WDATA);
    assign ADDR_WR = r_waddr;
    assign DIN     = WR ? HWDATA : '0;
    assign BSEL    = WR ? r_bsel : '0;

    // Reads launch in the address phase, or one cycle late after a hazard
    assign RD      = w_rd_now || (r_state == ST_RHAZ);
    assign ADDR_RD = (r_state == ST_RHAZ) ? r_raddr :
                     (w_rd_now ? HADDR[ADDR_BITS-1:0] : '0);

    // Read data passes through in RDATA and is held at all other times
    assign HRDATA  = (r_state == ST_RDATA) ? DOUT : r_hrdata;

    // Hold register behind the read data mux
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hrdata <= '0;
        end else begin
            r_hrdata <= HRDATA;
        end
    end

    // The bus must never hand over a transfer while this slave is stalling
    a_no_accept_in_stall: assert property (@(posedge clk) disable iff (!reset)
        !(w_accept && ((r_state == ST_RWAIT) || (r_state == ST_RHAZ) || (r_state == ST_ERR1))));

endmodule
`default_nettype wire

// File: tb/tb_ahb_slave_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_slave_ctrl
// Description : Self-checking bench for ahb_slave_ctrl. Two slaves share one
//               bus (READ_WAIT=0 and READ_WAIT=2), each backed by a simple
//               memory model. A pipelined AHB master walks a transfer table
//               and a scoreboard queue checks each completed data phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_slave_ctrl;
    import ahb_slave_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;

    logic        hreadyout [2];
    logic        hresp     [2];
    logic [31:0] hrdata    [2];
    logic        wr        [2];
    logic [15:0] addr_wr   [2];
    logic [31:0] din       [2];
    logic [3:0]  bsel      [2];
    logic        rd        [2];
    logic [15:0] addr_rd   [2];

    typedef struct {
        int          dut;
        bit          active;
        bit          write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        bit          haz;
        logic        exp_resp;
        int          exp_waits;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t seq  [$];
    vec_t sb_q [$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    assign hready = hreadyout[0] & hreadyout[1];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [31:0] mem [0:255];
        logic [31:0] mem_dout;

        ahb_slave_ctrl #(
            .ADDR_BITS (16),
            .DATA_BITS (32),
            .READ_WAIT (2 * g)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .HSEL      (hsel[g]),
            .HADDR     (haddr),
            .HTRANS    (htrans),
            .HWRITE    (hwrite),
            .HSIZE     (hsize),
            .HWDATA    (hwdata),
            .HREADY    (hready),
            .HREADYOUT (hreadyout[g]),
            .HRESP     (hresp[g]),
            .HRDATA    (hrdata[g]),
            .WR        (wr[g]),
            .ADDR_WR   (addr_wr[g]),
            .DIN       (din[g]),
            .BSEL      (bsel[g]),
            .RD        (rd[g]),
            .ADDR_RD   (addr_rd[g]),
            .DOUT      (mem_dout)
        );

        initial begin
            mem_dout = 32'h0;
            for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        end

        // Memory model: read data valid the cycle after RD, byte-masked writes
        always @(posedge clk) begin
            if (rd[g]) mem_dout <= mem[addr_rd[g][9:2]];
            if (wr[g]) begin
                for (int b = 0; b < 4; b++) begin
                    if (bsel[g][b]) mem[addr_wr[g][9:2]][8*b +: 8] <= din[g][8*b +: 8];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int dut, input bit active, input bit write,
                                input logic [31:0] addr, input logic [2:0] size,
                                input logic [31:0] wdata, input bit haz, input logic resp,
                                input int waits, input logic [31:0] rdata);
        vec_t v;
        v.dut = dut; v.active = active; v.write = write; v.addr = addr;
        v.size = size; v.wdata = wdata; v.haz = haz; v.exp_resp = resp;
        v.exp_waits = waits; v.exp_rdata = rdata;
        return v;
    endfunction

    function automatic logic [3:0] exp_bsel(input logic [31:0] addr, input logic [2:0] size);
        logic [7:0] m;
        m = 8'((1 << (1 << size)) - 1);
        m = m << addr[1:0];
        return m[3:0];
    endfunction

    task automatic drive_idle();
        hsel   = 2'b00;
        htrans = c_HTRANS_IDLE;
        haddr  = 32'h0;
        hwrite = 1'b0;
        hsize  = c_HSIZE_WORD;
    endtask

    task automatic drive_addr(input vec_t v);
        hsel        = 2'b00;
        hsel[v.dut] = 1'b1;
        haddr       = v.addr;
        hwrite      = v.write;
        hsize       = v.size;
        htrans      = v.active ? c_HTRANS_NONSEQ : c_HTRANS_IDLE;
    endtask

    task automatic check_reset_vals(input int d);
        chk("rst_hreadyout", 32'(hreadyout[d]), 32'd1);
        chk("rst_hresp",     32'(hresp[d]),     32'd0);
        chk("rst_hrdata",    hrdata[d],         32'd0);
        chk("rst_wr",        32'(wr[d]),        32'd0);
        chk("rst_rd",        32'(rd[d]),        32'd0);
        chk("rst_bsel",      32'(bsel[d]),      32'd0);
        chk("rst_addr_wr",   32'(addr_wr[d]),   32'd0);
        chk("rst_addr_rd",   32'(addr_rd[d]),   32'd0);
        chk("rst_din",       din[d],            32'd0);
    endtask

    // Pipelined master: called just after a rising edge, returns just after one
    task automatic run_seq();
        int   ai = 0;
        bit   dpv = 1'b0;
        int   waits = 0;
        int   cyc = 0;
        bit   exp_rd;
        vec_t dp;
        vec_t cur;
        vec_t e;
        while ((ai < seq.size() || dpv) && cyc < 200) begin
            if (ai < seq.size()) drive_addr(seq[ai]);
            else                 drive_idle();
            hwdata = (dpv && dp.write) ? dp.wdata : 32'h0;
            @(negedge clk);
            if (dpv) begin
                if (!hready) begin
                    waits++;
                    chk("wait_wr", 32'(wr[dp.dut]), 32'd0);
                    if (dp.exp_resp) begin
                        chk("err1_hresp", 32'(hresp[dp.dut]), 32'd1);
                        chk("err1_rd",    32'(rd[dp.dut]),    32'd0);
                    end
                end else begin
                    chk("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        chk("hresp", 32'(hresp[e.dut]), 32'(e.exp_resp));
                        chk("waits", 32'(waits), 32'(e.exp_waits));
                        if (e.exp_resp) begin
                            chk("err2_wr", 32'(wr[e.dut]), 32'd0);
                        end else if (e.write) begin
                            chk("wr",      32'(wr[e.dut]),      32'd1);
                            chk("bsel",    32'(bsel[e.dut]),    32'(exp_bsel(e.addr, e.size)));
                            chk("addr_wr", 32'(addr_wr[e.dut]), 32'(e.addr[15:0]));
                            chk("din",     din[e.dut],          e.wdata);
                        end else begin
                            chk("hrdata", hrdata[e.dut], e.exp_rdata);
                        end
                    end
                    dpv = 1'b0;
                end
            end
            if (hready && ai < seq.size()) begin
                cur = seq[ai];
                if (cur.active) begin
                    exp_rd = !cur.write && !cur.exp_resp && !cur.haz;
                    chk("accept_rd", 32'(rd[cur.dut]), 32'(exp_rd));
                    if (exp_rd) chk("addr_rd", 32'(addr_rd[cur.dut]), 32'(cur.addr[15:0]));
                    sb_q.push_back(cur);
                    dp    = cur;
                    dpv   = 1'b1;
                    waits = 0;
                end else begin
                    chk("idle_rd", 32'(rd[cur.dut]), 32'd0);
                end
                ai++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if (cyc >= 200) begin
            checks++;
            errors++;
            $display("FAIL run_seq_timeout: got %0d cycles expected under 200", cyc);
        end
        seq.delete();
        sb_q.delete();
        drive_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive_idle();
        hwdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) check_reset_vals(d);
        reset = 1'b1;
        @(posedge clk);
        #1;

        //           dut act wr  addr          sz    wdata          haz resp waits rdata
        seq.push_back(mk(0, 1, 1, 32'h0000_0100, 3'd2, 32'hDEADBEEF, 0, 0, 0, 32'h0));
        seq.push_back(mk(0, 0, 0, 32'h0,         3'd2, 32'h0,        0, 0, 0, 32'h0));
        seq.push_back(mk(0, 1, 0, 32'h0000_0100, 3'd2, 32'h0,        0, 0, 0, 32'hDEADBEEF));
        seq.push_back(mk(0, 1, 1, 32'h0000_0102, 3'd0, 32'h00AA0000, 0, 0, 0, 32'h0));
        seq.push_back(mk(0, 0, 0, 32'h0,         3'd2, 32'h0,        0, 0, 0, 32'h0));
        seq.push_back(mk(0, 1, 0, 32'h0000_0100, 3'd2, 32'h0,        0, 0, 0, 32'hDEAABEEF));
        seq.push_back(mk(0, 1, 1, 32'h0000_0200, 3'd2, 32'h12345678, 0, 0, 0, 32'h0));
        seq.push_back(mk(0, 1, 0, 32'h0000_0200, 3'd2, 32'h0,        1, 0, 1, 32'h12345678));
        seq.push_back(mk(0, 1, 1, 32'h0000_0204, 3'd2, 32'hCAFEF00D, 0, 0, 0, 32'h0));
        seq.push_back(mk(0, 1, 0, 32'h0000_0100, 3'd2, 32'h0,        0, 0, 0, 32'hDEAABEEF));
        seq.push_back(mk(0, 1, 1, 32'h0000_0206, 3'd1, 32'hBEEF0000, 0, 0, 0, 32'h0));
        seq.push_back(mk(0, 0, 0, 32'h0,         3'd2, 32'h0,        0, 0, 0, 32'h0));
        seq.push_back(mk(0, 1, 0, 32'h0000_0204, 3'd2, 32'h0,        0, 0, 0, 32'hBEEFF00D));
        seq.push_back(mk(0, 1, 0, 32'h0001_0000, 3'd2, 32'h0,        0, 1, 1, 32'h0));
        seq.push_back(mk(0, 1, 0, 32'h0000_0101, 3'd1, 32'h0,        0, 1, 1, 32'h0));
        seq.push_back(mk(0, 1, 1, 32'h0000_0108, 3'd3, 32'h11111111, 0, 1, 1, 32'h0));
        seq.push_back(mk(0, 0, 0, 32'h0,         3'd2, 32'h0,        0, 0, 0, 32'h0));
        seq.push_back(mk(1, 1, 1, 32'h0000_0100, 3'd2, 32'h0BADCAFE, 0, 0, 0, 32'h0));
        seq.push_back(mk(1, 0, 0, 32'h0,         3'd2, 32'h0,        0, 0, 0, 32'h0));
        seq.push_back(mk(1, 1, 0, 32'h0000_0100, 3'd2, 32'h0,        0, 0, 2, 32'h0BADCAFE));
        seq.push_back(mk(1, 1, 1, 32'h0000_0300, 3'd2, 32'h55AA55AA, 0, 0, 0, 32'h0));
        seq.push_back(mk(1, 1, 0, 32'h0000_0300, 3'd2, 32'h0,        1, 0, 3, 32'h55AA55AA));
        seq.push_back(mk(1, 0, 0, 32'h0,         3'd2, 32'h0,        0, 0, 0, 32'h0));
        run_seq();

        // Reset while the READ_WAIT=2 slave is stalled in its wait states
        hsel   = 2'b10;
        haddr  = 32'h0000_0100;
        htrans = c_HTRANS_NONSEQ;
        hwrite = 1'b0;
        hsize  = c_HSIZE_WORD;
        @(negedge clk);
        chk("rst_seq_accept_rd", 32'(rd[1]), 32'd1);
        @(posedge clk);
        #1;
        drive_idle();
        @(negedge clk);
        chk("rst_seq_stalled", 32'(hreadyout[1]), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals(1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_wr",        32'(wr[1]),        32'd0);
        chk("post_rst_rd",        32'(rd[1]),        32'd0);
        chk("post_rst_hreadyout", 32'(hreadyout[1]), 32'd1);
        @(posedge clk);
        #1;

        seq.push_back(mk(1, 1, 1, 32'h0000_0104, 3'd2, 32'h600DF00D, 0, 0, 0, 32'h0));
        seq.push_back(mk(1, 0, 0, 32'h0,         3'd2, 32'h0,        0, 0, 0, 32'h0));
        seq.push_back(mk(1, 1, 0, 32'h0000_0104, 3'd2, 32'h0,        0, 0, 2, 32'h600DF00D));
        seq.push_back(mk(1, 0, 0, 32'h0,         3'd2, 32'h0,        0, 0, 0, 32'h0));
        run_seq();

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
